rr_arb_mux: RTL and testbench

- Parametrised N-channel, DATA_W-bit registered multiplexer with valid/ready handshakes on every input channel and on the output.
- Selects channels by round-robin arbitration, or by an explicit select (fixed mode), and presents the winner through a one-entry output register.
- Sits between multiple stream producers and one shared consumer. It generalises the 4:1 bit mux to wide data, any channel count, flow control and fairness.

---
 rtl/rr_arb_mux.sv | 153 +++++++++++++++
 tb/tb_rr_arb_mux.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//
// N_CH-channel, DATA_W-bit registered multiplexer with valid/ready handshakes
// on every input and on the output. In mode 0 the channels are arbitrated
// round-robin; in mode 1 the channel named by sel is the only candidate. The
// winning word goes into a one-entry output register, which can drain and
// refill in the same cycle so a continuous stream runs at full throughput.
//
// Optional build macro: RR_ARB_MUX_STATS_EN
//   When defined, adds saturating 16-bit handshake and stall counters.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = round-robin, 1 = fixed select via sel
//   sel        channel index used when mode = 1
//   in_valid   per-channel valid, bit k = channel k
//   in_data    packed channel data, channel k at [k*DATA_W +: DATA_W]
//   in_ready   per-channel accept, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered data
//   out_ch     source channel of out_data
//   out_ready  consumer accepts the held word
//   xfer_cnt   (stats build) count of out_valid & out_ready cycles
//   stall_cnt  (stats build) count of out_valid & !out_ready cycles
// -----------------------------------------------------------------------------
module rr_arb_mux #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [N_CH-1:0]          in_valid,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   output logic [N_CH-1:0]          in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
`ifdef RR_ARB_MUX_STATS_EN
   ,
   output logic [15:0]              xfer_cnt,
   output logic [15:0]              stall_cnt
`endif
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]        state;
   logic [SEL_W-1:0]  ptr;

   logic              can_load;
   logic              rr_found;
   logic [SEL_W-1:0]  rr_win;
   logic              fix_hit;
   logic              win_valid;
   logic [SEL_W-1:0]  win_ch;
   logic [DATA_W-1:0] win_data;
   logic              grant;

   assign out_valid = (state == ST_FULL);

   // The register may load when empty, or when full and being drained this
   // cycle. Holding rst low here keeps in_ready at zero throughout reset.
   assign can_load = !rst && ((state == ST_EMPTY) || out_ready);

   // Round-robin search starting at ptr and wrapping past N_CH-1 to 0.
   // NOTE: every signal driven in always_comb gets a default before any
   // conditional assignment, otherwise a latch is inferred.
   always_comb begin
      rr_found = 1'b0;
      rr_win   = '0;
      for (int i = 0; i < N_CH; i++) begin
         int idx;
         idx = (int'(ptr) + i) % N_CH;
         if (!rr_found && in_valid[idx]) begin
            rr_found = 1'b1;
            rr_win   = SEL_W'(idx);
         end
      end
   end

   // Out-of-range select values (possible when N_CH is not a power of two)
   // never grant.
   assign fix_hit = (int'(sel) < N_CH) && in_valid[sel];

   assign win_valid = mode ? fix_hit : rr_found;
   assign win_ch    = mode ? sel     : rr_win;
   assign grant     = can_load && win_valid;

   always_comb begin
      win_data = in_data[int'(win_ch)*DATA_W +: DATA_W];
   end

   // in_ready depends only on our own register state and the arbitration
   // result, never on out_data.
   always_comb begin
      in_ready = '0;
      if (grant) begin
         in_ready[win_ch] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_EMPTY;
         out_data <= '0;
         out_ch   <= '0;
         ptr      <= '0;
      end else if (can_load) begin
         if (grant) begin
            state    <= ST_FULL;
            out_data <= win_data;
            out_ch   <= win_ch;
            // Only round-robin grants move the pointer; fixed-mode traffic
            // leaves the fairness position where it was.
            if (!mode) begin
               ptr <= (win_ch == SEL_W'(N_CH - 1)) ? '0 : win_ch + SEL_W'(1);
            end
         end else begin
            // Drained with nothing to refill; out_data keeps a stale value.
            state <= ST_EMPTY;
         end
      end
   end

`ifdef RR_ARB_MUX_STATS_EN
   // Saturating event counters, updated the cycle after each event.
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (out_valid && out_ready && (xfer_cnt != 16'hFFFF)) begin
            xfer_cnt <= xfer_cnt + 16'd1;
         end
         if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`else
   // Statistics disabled: no counter hardware is built.
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
//
// Directed bench for rr_arb_mux (N_CH=4, DATA_W=8). Each stimulus cycle names
// the hand-computed in_ready pattern and out_valid level; a granted word is
// pushed into a scoreboard queue and a separate monitor pops and compares it
// when the output handshakes. Define RR_ARB_MUX_STATS_EN to also exercise the
// statistics counters.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;

   localparam int N_CH   = 4;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 2;

   typedef struct packed {
      logic [SEL_W-1:0]  ch;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic                   clk;
   logic                   rst;
   logic                   mode;
   logic [SEL_W-1:0]       sel;
   logic [N_CH-1:0]        in_valid;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_ready;
   logic                   out_valid;
   logic [DATA_W-1:0]      out_data;
   logic [SEL_W-1:0]       out_ch;
   logic                   out_ready;
`ifdef RR_ARB_MUX_STATS_EN
   logic [15:0]            xfer_cnt;
   logic [15:0]            stall_cnt;
`endif

   logic [DATA_W-1:0] dat [N_CH];
   exp_t              sb_q[$];
   int                n_chk;
   int                n_pass;
   logic              mon_en;

   rr_arb_mux #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
`ifdef RR_ARB_MUX_STATS_EN
      ,
      .xfer_cnt  (xfer_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         in_data[k*DATA_W +: DATA_W] = dat[k];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // One clock cycle of stimulus: inputs are already applied (posedge+1).
   // Checks in_ready and out_valid mid-cycle, records the expected word for
   // the granted channel, then advances to just after the next rising edge.
   task automatic cyc(input logic [N_CH-1:0] exp_rdy, input logic exp_ov);
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      for (int k = 0; k < N_CH; k++) begin
         if (exp_rdy[k]) begin
            sb_q.push_back('{ch: SEL_W'(k), data: dat[k]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every output handshake against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && (out_valid === 1'b1) && (out_ready === 1'b1)) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output", 32'(out_ch), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("out_ch", 32'(out_ch), 32'(e.ch));
               check("out_data", 32'(out_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      mon_en    = 1'b1;
      rst       = 1'b1;
      mode      = 1'b0;
      sel       = '0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      dat[0]    = 8'hA0;
      dat[1]    = 8'hB1;
      dat[2]    = 8'hC2;
      dat[3]    = 8'hD3;

      // Reset held two cycles with every channel requesting.
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      check("rst_out_ch", 32'(out_ch), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      rst = 1'b0;

      // Round-robin fairness: 0,1,2,3,0,1 back to back.
      cyc(4'b0001, 1'b0);
      cyc(4'b0010, 1'b1);
      cyc(4'b0100, 1'b1);
      cyc(4'b1000, 1'b1);
      cyc(4'b0001, 1'b1);
      cyc(4'b0010, 1'b1);

      // Pointer now 2; a lone ch0 request wins and leaves the pointer at 1.
      in_valid = 4'b0001;
      cyc(4'b0001, 1'b1);

      // Skip and wrap from pointer 1 with channels 0 and 3 requesting.
      in_valid = 4'b1001;
      cyc(4'b1000, 1'b1);
      cyc(4'b0001, 1'b1);
      cyc(4'b1000, 1'b1);
      in_valid = 4'b0000;
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b0);

      // Backpressure: load 5A from ch2 (pointer 0 -> search 0,1,2).
      dat[2]   = 8'h5A;
      in_valid = 4'b0100;
      cyc(4'b0100, 1'b0);
      in_valid  = 4'b0001;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(4'b0000, 1'b1);
         check("hold_data", 32'(out_data), 32'h5A);
         check("hold_ch", 32'(out_ch), 32'h2);
      end
      // Release: drain and refill in the same cycle (pointer 3 -> ch0).
      out_ready = 1'b1;
      cyc(4'b0001, 1'b1);

      // Fixed mode, sel=2 with only ch0/ch1 requesting: nothing granted.
      mode     = 1'b1;
      sel      = 2'd2;
      in_valid = 4'b0011;
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b0);
      dat[2]   = 8'hC3;
      in_valid = 4'b0111;
      cyc(4'b0100, 1'b0);
      in_valid = 4'b0000;
      cyc(4'b0000, 1'b1);
      check("fix_out_data", 32'(out_data), 32'hC3);

      // Back to round-robin: pointer still 1 from the ch0 grant above.
      mode     = 1'b0;
      in_valid = 4'b1111;
      cyc(4'b0010, 1'b0);
      in_valid = 4'b0000;
      cyc(4'b0000, 1'b1);

      // Reset mid-operation: held word discarded, pointer back to 0.
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      cyc(4'b0100, 1'b0);
      rst = 1'b1;
      cyc(4'b0000, 1'b1);
      void'(sb_q.pop_front());
      rst       = 1'b0;
      out_ready = 1'b1;
      cyc(4'b0001, 1'b0);
      in_valid = 4'b0000;
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b0);

`ifdef RR_ARB_MUX_STATS_EN
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("stats_rst_xfer", 32'(xfer_cnt), 32'h0);
      check("stats_rst_stall", 32'(stall_cnt), 32'h0);
      in_valid = 4'b0001;
      cyc(4'b0001, 1'b0);
      in_valid = 4'b0010;
      cyc(4'b0010, 1'b1);
      in_valid = 4'b0100;
      cyc(4'b0100, 1'b1);
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(4'b0000, 1'b1);
      end
      out_ready = 1'b1;
      cyc(4'b0000, 1'b1);
      check("xfer_cnt", 32'(xfer_cnt), 32'd3);
      check("stall_cnt", 32'(stall_cnt), 32'd4);

      // Saturation: 70000 back-to-back handshakes.
      mon_en   = 1'b0;
      in_valid = 4'b1111;
      repeat (70000) @(posedge clk);
      #1;
      check("xfer_sat", 32'(xfer_cnt), 32'hFFFF);
      check("stall_kept", 32'(stall_cnt), 32'd4);
      in_valid = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
`endif

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
